ccff_chain_loader: RTL and testbench

//  Drives a configuration-chain (ccff_head -> ... -> ccff_tail) from a word-wide bitstream source: serialises

---
 rtl/ccff_loader_pkg.sv | 25 ++
 rtl/ccff_word_serializer.sv | 58 +++++
 rtl/ccff_chain_loader.sv | 130 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    DATA,
    DONE
  } state_t;

  // Default continuity marker, shifted MSB first ahead of the data.
  localparam logic [7:0] MARKER_DEFAULT = 8'hA5;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that hands bitstream words to the chain one bit at a time, MSB first.
// Latency: a word accepted on an edge supplies its MSB in the following cycle.
// Backpressure: ready only while active, words still needed, and buffer empty or draining its last bit.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              clear,
  input  logic              active,
  input  logic              shift_in,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              bit_msb,
  output logic              has_bit
);

  localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int WCW    = cnt_width(NWORDS);
  localparam int BCW    = cnt_width(WORD_W);
  localparam logic [WCW-1:0] WC_MAX  = WCW'(NWORDS);
  localparam logic [BCW-1:0] BC_FULL = BCW'(WORD_W);
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);

  logic [WORD_W-1:0] word_q;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic              accept;

  assign has_bit = (bit_cnt != '0);
  assign bit_msb = word_q[WORD_W-1];

  // Refill in the same cycle the last bit leaves so a steady source never bubbles.
  assign word_ready_o = active && (word_cnt != WC_MAX) &&
                        (!has_bit || ((bit_cnt == BC_ONE) && shift_in));
  assign accept = word_ready_o && word_valid_i;

  // Load a fresh word or shift the current one; leftover low bits die at the next clear.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || clear) begin
      word_q   <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      word_q   <= word_i;
      bit_cnt  <= BC_FULL;
      word_cnt <= word_cnt + 1'b1;
    end else if (shift_in) begin
      word_q  <= word_q << 1;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a config chain: marker then data onto ccff_head, checks the marker returns at ccff_tail.
// Latency: start edge + MARKER_LEN+CHAIN_LEN shift cycles + 1 DONE cycle when the source never stalls.
// Backpressure: an empty word buffer in DATA stalls the chain (shift_en_o low, shift index frozen).
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int                CHAIN_LEN  = 10,
  parameter int                WORD_W     = 8,
  parameter int                MARKER_LEN = 8,
  parameter logic [WORD_W-1:0] MARKER     = MARKER_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o
);

  localparam int JW = cnt_width(MARKER_LEN + CHAIN_LEN);
  localparam logic [JW-1:0] J_MARK_LAST = JW'(MARKER_LEN - 1);
  localparam logic [JW-1:0] J_LAST      = JW'(MARKER_LEN + CHAIN_LEN - 1);
  localparam logic [JW-1:0] J_CHK_FIRST = JW'(CHAIN_LEN);

  state_t            state_q, state_nxt;
  logic [JW-1:0]     j_q;
  logic [WORD_W-1:0] mark_sr;
  logic [WORD_W-1:0] chk_sr;
  logic              mismatch_q;
  logic              active;
  logic              has_bit;
  logic              bit_msb;
  logic              start_acc;
  logic              data_shift;
  logic              last_shift;
  logic              tail_chk;
  logic              tail_bad;

  assign start_acc  = (state_q == IDLE) && start_i;
  assign data_shift = (state_q == DATA) && has_bit;
  assign last_shift = data_shift && (j_q == J_LAST);
  // Once the marker has travelled the full chain, each shift presents one marker bit at the tail.
  assign tail_chk   = shift_en_o && (j_q >= J_CHK_FIRST);
  assign tail_bad   = tail_chk && (ccff_tail != chk_sr[WORD_W-1]);

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .clear        (start_acc),
    .active       (active),
    .shift_in     (data_shift),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .bit_msb      (bit_msb),
    .has_bit      (has_bit)
  );

  // Load-sequencer state register.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_nxt;
  end

  // Next state plus chain-facing outputs decoded from the current state.
  always_comb begin
    state_nxt  = state_q;
    shift_en_o = 1'b0;
    ccff_head  = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    active     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_nxt = MARK;
      end
      MARK: begin
        shift_en_o = 1'b1;
        ccff_head  = mark_sr[WORD_W-1];
        busy_o     = 1'b1;
        active     = 1'b1;
        if (j_q == J_MARK_LAST) state_nxt = DATA;
      end
      DATA: begin
        shift_en_o = has_bit;
        ccff_head  = bit_msb;
        busy_o     = 1'b1;
        active     = 1'b1;
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift index, marker source/check shifters, sticky mismatch and the held pass result.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      j_q        <= '0;
      mark_sr    <= '0;
      chk_sr     <= '0;
      mismatch_q <= 1'b0;
      pass_o     <= 1'b0;
    end else if (start_acc) begin
      j_q        <= '0;
      mark_sr    <= MARKER;
      chk_sr     <= MARKER;
      mismatch_q <= 1'b0;
    end else if (shift_en_o) begin
      j_q <= j_q + 1'b1;
      if (state_q == MARK) mark_sr <= mark_sr << 1;
      if (tail_chk)        chk_sr <= chk_sr << 1;
      if (tail_bad)        mismatch_q <= 1'b1;
      if (last_shift)      pass_o <= ~(mismatch_q | tail_bad);
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for the chain loader with a per-cycle reference model.
// Latency: n/a.
// Backpressure: the bench source follows the valid/ready handshake.
module tb_ccff_chain_loader;

  localparam int CL = 10;
  localparam int WW = 8;
  localparam int ML = 8;
  localparam int NW = 2;

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start_i;
  logic [WW-1:0] word_i;
  logic          word_valid_i;
  logic          word_ready_o;
  logic          ccff_head;
  logic          ccff_tail;
  logic          shift_en_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;

  // Bench-side chain of configurable length; head enters chain[0], tail is chain[chain_len-1].
  logic [15:0]   chain = '0;
  int            chain_len = CL;
  bit            stuck = 1'b0;

  logic [WW-1:0] wl [NW];
  logic [7:0]    marker_v = 8'hA5;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            m_load = 1'b0;
  bit            m_done = 1'b0;
  int            m_idx = 0;
  int            m_words = 0;
  logic [WW-1:0] m_wq [NW];

  // Observed statistics
  int acc_total = 0, shift_total = 0, stall_total = 0, done_total = 0;
  int run_len = 0, max_run = 0;

  ccff_chain_loader #(
    .CHAIN_LEN  (CL),
    .WORD_W     (WW),
    .MARKER_LEN (ML),
    .MARKER     (8'hA5)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start_i      (start_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .shift_en_o   (shift_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = stuck ? 1'b0 : chain[chain_len-1];

  always @(posedge prog_clk) begin
    if (shift_en_o === 1'b1) chain <= {chain[14:0], ccff_head};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge prog_clk) begin
    bit e_shift, e_ready, e_head;
    int dsh, dd;
    dsh = (m_idx > ML) ? (m_idx - ML) : 0;
    e_shift = m_load && ((m_idx < ML) || (dsh < WW * m_words));
    e_ready = m_load && (m_words < NW) &&
              ((WW * m_words == dsh) || ((WW * m_words == dsh + 1) && e_shift));
    chk("busy_o", busy_o, m_load);
    chk("done_o", done_o, m_done);
    chk("shift_en_o", shift_en_o, e_shift);
    chk("word_ready_o", word_ready_o, e_ready);
    if (e_shift) begin
      if (m_idx < ML) e_head = marker_v[WW-1-m_idx];
      else begin
        dd = m_idx - ML;
        e_head = m_wq[dd / WW][WW-1-(dd % WW)];
      end
      chk("ccff_head", ccff_head, e_head);
    end
    if (m_done) chk("pass_at_done", pass_o, (chain_len == CL) && !stuck);

    if (word_valid_i && word_ready_o) acc_total++;
    if (busy_o && !shift_en_o) stall_total++;
    if (done_o) done_total++;
    if (shift_en_o) begin
      shift_total++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;

    if (prog_reset) begin
      m_load = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_load) begin
      if (start_i) begin
        m_load = 1'b1;
        m_idx = 0;
        m_words = 0;
        max_run = 0;
      end
    end else begin
      if (word_valid_i && e_ready) begin
        m_wq[m_words] = word_i;
        m_words++;
      end
      if (e_shift) begin
        m_idx++;
        if (m_idx == ML + CL) begin
          m_load = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // One full load; gap = cycles the source withholds the second word while ready.
  task automatic do_load(input int gap, input bit toggle, output int lat);
    int idx, low_seen, cyc;
    bit acc;
    idx = 0; low_seen = 0; cyc = 0;
    start_i = 1'b1;
    @(posedge prog_clk); #1;
    start_i = 1'b0;
    word_i = wl[0];
    word_valid_i = 1'b1;
    while (done_o !== 1'b1 && cyc < 100) begin
      @(negedge prog_clk);
      acc = word_valid_i && word_ready_o;
      if (!word_valid_i && word_ready_o) low_seen++;
      @(posedge prog_clk); #1;
      cyc++;
      if (toggle) start_i = ~start_i;
      if (acc) begin
        idx++;
        if (idx < NW) begin
          word_i = wl[idx];
          word_valid_i = (gap == 0);
        end
        low_seen = 0;
      end else if (idx < NW && !word_valid_i && low_seen >= gap) begin
        word_valid_i = 1'b1;
      end
    end
    chk("load_reached_done", done_o, 1'b1);
    lat = cyc;
    start_i = 1'b0;
    word_valid_i = 1'b0;
    @(posedge prog_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, a0, st0, s0, n;
    wl[0] = 8'hC3;
    wl[1] = 8'h80;
    prog_reset = 1'b1; start_i = 1'b0; word_valid_i = 1'b0; word_i = '0;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_shift", shift_en_o, 1'b0);
    chk("rst_ready", word_ready_o, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_pass", pass_o, 1'b0);
    repeat (2) @(posedge prog_clk);
    #1;

    // 1: continuous source
    d0 = done_total; a0 = acc_total; st0 = stall_total;
    do_load(0, 1'b0, lat);
    chk("s1_latency", lat, 18);
    chk("s1_words", acc_total - a0, 2);
    chk("s1_run", max_run, 18);
    chk("s1_stalls", stall_total - st0, 0);
    chk("s1_dones", done_total - d0, 1);
    chk("s1_chain", chain[9:0], 10'b1100001110);
    chk("s1_pass", pass_o, 1'b1);

    // 2: wrong chain lengths
    chain_len = 9;
    do_load(0, 1'b0, lat);
    chk("s2_len9_pass", pass_o, 1'b0);
    chain_len = 11;
    do_load(0, 1'b0, lat);
    chk("s2_len11_pass", pass_o, 1'b0);
    chain_len = CL;

    // 3: source gap between words
    st0 = stall_total; a0 = acc_total;
    do_load(5, 1'b0, lat);
    chk("s3_stalls", stall_total - st0, 5);
    chk("s3_latency", lat, 23);
    chk("s3_words", acc_total - a0, 2);
    chk("s3_chain", chain[9:0], 10'b1100001110);
    chk("s3_pass", pass_o, 1'b1);

    // 4: reset in the middle of a load
    s0 = shift_total;
    start_i = 1'b1;
    @(posedge prog_clk); #1;
    start_i = 1'b0; word_i = wl[0]; word_valid_i = 1'b1;
    n = 0;
    while ((shift_total - s0) < 12 && n < 60) begin
      @(posedge prog_clk); #1;
      n++;
    end
    chk("s4_shifts_before_reset", shift_total - s0, 12);
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;
    prog_reset = 1'b0; word_valid_i = 1'b0;
    chk("s4_busy", busy_o, 1'b0);
    chk("s4_shift", shift_en_o, 1'b0);
    chk("s4_ready", word_ready_o, 1'b0);
    chk("s4_pass", pass_o, 1'b0);
    chk("s4_done", done_o, 1'b0);
    repeat (2) @(posedge prog_clk);
    #1;
    do_load(0, 1'b0, lat);
    chk("s4_reload_pass", pass_o, 1'b1);
    chk("s4_reload_chain", chain[9:0], 10'b1100001110);

    // 5: stuck tail, then start toggling during a load
    stuck = 1'b1;
    do_load(0, 1'b0, lat);
    chk("s5_stuck_pass", pass_o, 1'b0);
    stuck = 1'b0;
    d0 = done_total;
    do_load(0, 1'b1, lat);
    chk("s5_toggle_dones", done_total - d0, 1);
    chk("s5_toggle_latency", lat, 18);
    chk("s5_toggle_pass", pass_o, 1'b1);

    // 6: back-to-back loads, second start in the cycle after done
    d0 = done_total;
    do_load(0, 1'b0, lat);
    chk("s6_first_pass", pass_o, 1'b1);
    do_load(0, 1'b0, lat);
    chk("s6_second_latency", lat, 18);
    chk("s6_second_pass", pass_o, 1'b1);
    chk("s6_dones", done_total - d0, 2);

    repeat (3) @(posedge prog_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
